// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter with its own bit-period counter; busy/done handshake to the byte producer.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits (11-bit frame).
module uart_tx_module #(
    parameter logic [12:0] BPS = 13'd434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en_sig,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done_sig,
    output logic       tx_pin
);

    localparam int unsigned CNT_W = 13;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS - 13'd1);
    // The done/idle cycle doubles as the last stop-bit cycle, so back-to-back frames stay contiguous.
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(BPS - 13'd2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               pin_q, pin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pin_d   = pin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                pin_d = 1'b1;
                if (tx_en_sig) begin
                    state_d = S_START;
                    shift_d = tx_data;
                    idx_d   = '0;
                    pin_d   = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    pin_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        pin_d   = parity_q;
`else
                        state_d = S_STOP;
                        pin_d   = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = {1'b0, shift_q[7:1]};
                        pin_d   = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    pin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pin_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_pin      = pin_q;
    assign tx_busy     = busy_q;
    assign tx_done_sig = done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Self-checking bench for uart_tx_module (BPS=4): per-cycle frame model plus directed literal checks.
module tb_uart_tx_module;

    localparam int BPS = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * BPS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en_sig = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done_sig, tx_pin;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: m_t = cycles into the current frame (0 = idle), m_bits = line levels of that frame.
    int   m_t = 0;
    int   m_frames = 0;
    logic m_bits [0:10];

    logic rec_pin  [1:200];
    logic rec_done [1:200];

    uart_tx_module #(.BPS(13'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en_sig  (tx_en_sig),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done_sig(tx_done_sig),
        .tx_pin     (tx_pin)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0;
        end else if ((m_t == 0 || m_t == F) && tx_en_sig) begin
            m_t = 1;
            m_frames++;
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[i+1] = tx_data[i];
`ifdef UART_TX_PARITY_EN
            m_bits[9]  = ^tx_data;
            m_bits[10] = 1'b1;
`else
            m_bits[9] = 1'b1;
`endif
        end else if (m_t != 0) begin
            m_t = (m_t == F) ? 0 : m_t + 1;
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("model_pin",  int'(tx_pin),      (m_t == 0) ? 1 : int'(m_bits[(m_t-1)/BPS]));
            check("model_busy", int'(tx_busy),     (m_t != 0 && m_t != F) ? 1 : 0);
            check("model_done", int'(tx_done_sig), (m_t == F) ? 1 : 0);
        end
    end

    // Request on the next edge; leaves us at the sample point of frame cycle 1.
    task automatic accept(input logic [7:0] d, input bit keep);
        @(negedge clk);
        tx_data   = d;
        tx_en_sig = 1'b1;
        @(posedge clk);
        #2;
        if (!keep) tx_en_sig = 1'b0;
    endtask

    task automatic rec(input int c);
        rec_pin[c]  = tx_pin;
        rec_done[c] = tx_done_sig;
    endtask

    task automatic next_sample;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_gap(input int n);
        tx_en_sig = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic int done_at(input int n);
        int pos = 0;
        int cnt = 0;
        for (int c = 1; c <= n; c++) if (rec_done[c]) begin cnt++; pos = c; end
        return (cnt == 1) ? pos : -cnt;
    endfunction

    task automatic check_byte(input string nm, input logic [7:0] d);
        logic [7:0] got;
        for (int j = 0; j < 8; j++) got[j] = rec_pin[BPS*(j+1) + 2];
        check(nm, int'(got), int'(d));
    endtask

    initial begin
        int errs;
        #5 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset and idle
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || tx_done_sig !== 1'b0) errs++;
        end
        check("idle_after_reset", errs, 0);

        // Single byte 8'h55
        accept(8'h55, 1'b0);
        for (int c = 1; c <= F; c++) begin rec(c); next_sample(); end
        errs = 0;
        for (int c = 1; c <= 36; c++) if (rec_pin[c] !== 1'(((c-1)/BPS) % 2)) errs++;
        check("h55_waveform", errs, 0);
        check("h55_stop", int'({rec_pin[F-3], rec_pin[F-2], rec_pin[F-1], rec_pin[F]}), 15);
        check("h55_done_cycle", done_at(F), F);
        idle_gap(10);

        // Busy rejection
        accept(8'hA3, 1'b0);
        for (int c = 1; c <= F + 20; c++) begin
            rec(c);
            if (c == 15) begin tx_data = 8'hFF; tx_en_sig = 1'b1; end
            if (c == 16) tx_en_sig = 1'b0;
            next_sample();
        end
        check_byte("busy_frame_data", 8'hA3);
        check("busy_single_done", done_at(F + 20), F);
        errs = 0;
        for (int c = F + 1; c <= F + 20; c++) if (rec_pin[c] !== 1'b1) errs++;
        check("busy_no_second_frame", errs, 0);
        idle_gap(10);

        // Back-to-back with held request
        accept(8'h00, 1'b1);
        for (int c = 1; c <= 2*F; c++) begin
            rec(c);
            if (c == F) tx_data = 8'hFF;
            if (c == F + 1) tx_en_sig = 1'b0;
            next_sample();
        end
        check_byte("b2b_first_data", 8'h00);
        check("b2b_gap_stop", int'({rec_pin[F-3], rec_pin[F-2], rec_pin[F-1], rec_pin[F]}), 15);
        check("b2b_second_start", int'(rec_pin[F+1]), 0);
        check("b2b_second_start_len", int'({rec_pin[F+1], rec_pin[F+2], rec_pin[F+3], rec_pin[F+4]}), 0);
        errs = 0;
        for (int c = F + 5; c <= F + 36; c++) if (rec_pin[c] !== 1'b1) errs++;
        check("b2b_second_data_ones", errs, 0);
        check("b2b_done_first", int'(rec_done[F]), 1);
        check("b2b_done_second", int'(rec_done[2*F]), 1);
        idle_gap(10);

        // Reset mid-frame during data bit 3 of 8'h0F
        accept(8'h0F, 1'b0);
        for (int c = 1; c <= 18; c++) begin rec(c); if (c < 18) next_sample(); end
        check("rst_pre_bit3", int'(rec_pin[18]), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_pin", int'(tx_pin), 1);
        check("rst_async_busy", int'(tx_busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        errs = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_done_sig !== 1'b0 || tx_pin !== 1'b1) errs++;
        end
        check("rst_no_done", errs, 0);
        accept(8'hC6, 1'b0);
        for (int c = 1; c <= F; c++) begin rec(c); next_sample(); end
        check_byte("post_rst_data", 8'hC6);
        check("post_rst_done", done_at(F), F);
        idle_gap(10);

`ifdef UART_TX_PARITY_EN
        accept(8'h07, 1'b0);
        for (int c = 1; c <= F; c++) begin rec(c); next_sample(); end
        check("par07_bit", int'(rec_pin[BPS*9 + 2]), 1);
        check("par07_len", done_at(F), 44);
        idle_gap(10);
        accept(8'h03, 1'b0);
        for (int c = 1; c <= F; c++) begin rec(c); next_sample(); end
        check("par03_bit", int'(rec_pin[BPS*9 + 2]), 0);
        idle_gap(10);
`endif

        // Randomized requests and data churn against the model
        m_frames = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tx_en_sig = ($urandom_range(0, 5) == 0);
            tx_data   = 8'($urandom);
        end
        tx_en_sig = 1'b0;
        check("random_frames_seen", int'(m_frames > 20), 1);
        repeat (F + 5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
# uart_tx_module

UART transmitter paired with the receive-side baud counter and sampler. It accepts one byte per request and serialises it onto `tx_pin` as an 8N1 frame: one start bit, 8 data bits LSB first, one stop bit. An optional even-parity bit is compiled in by macro. It owns its own bit-period counter, reports busy and done to the requesting logic, and sits between the byte-producing control logic and the UART TX pad.

## Interface
- `BPS`, 13'd434: bit period in `clk` cycles (50 MHz / 115200); legal range 2..8191.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_en_sig`  in  1  transmit request; qualified only while `tx_busy` = 0.
- `tx_data`  in  8  byte to send; sampled in the accepting cycle only.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done_sig`  out  1  one-cycle pulse when a frame completes.
- `tx_pin`  out  1  serial line; idles high.

## Operation
- Reset values: `tx_pin` = 1, `tx_busy` = 0, `tx_done_sig` = 0, state IDLE, bit counter 0, bit index 0.
- States:
  - IDLE: `tx_pin` = 1.
  - START: `tx_pin` = 0.
  - DATA: `tx_pin` = shift register bit 0.
  - PARITY: `tx_pin` = XOR of the 8 latched bits. Present only with the macro.
  - STOP: `tx_pin` = 1.
- Transitions:
  - IDLE→START when `tx_en_sig` = 1. `tx_data` latches into the shift register; `tx_busy` rises.
  - START→DATA after BPS cycles.
  - DATA advances one bit every BPS cycles. After bit 7: DATA→PARITY (macro) or DATA→STOP.
  - PARITY→STOP after BPS cycles.
  - STOP→IDLE after BPS cycles.
- Bit counter: 13-bit, counts 0..BPS-1, clears on reaching BPS-1 and on every state change. It holds 0 in IDLE.
- Bit index: 3-bit, 0..7, increments at each DATA bit boundary.
- `tx_pin`, `tx_busy` and `tx_done_sig` are registered outputs; there is no combinational path from any input.
- Requests while busy: `tx_en_sig` is ignored and nothing is queued. Changes on `tx_data` while busy have no effect on the frame in progress.
- Done and back-to-back frames:
  - In the cycle the FSM re-enters IDLE, `tx_done_sig` = 1 and `tx_busy` = 0.
  - A `tx_en_sig` in that same cycle is accepted.
  - The next start bit then follows with exactly one stop bit between frames.
- Reset mid-frame: outputs return to reset values immediately, and no `tx_done_sig` is generated for the aborted frame.

## Timing
- Accept edge = rising edge at which IDLE and `tx_en_sig` = 1.
- `tx_pin` falls on the accept edge, so the start bit is visible in the first cycle after it. `tx_busy` rises on the same edge.
- Each bit is held for exactly BPS cycles.
- Frame length F = 10·BPS cycles, or 11·BPS cycles with the macro.
- `tx_done_sig` asserts F cycles after the accept edge and lasts 1 cycle.
- With a continuous request, the period between accept edges is exactly F cycles.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is present; the frame is 11 bits.
  - Parity is even: the number of ones across the data bits plus the parity bit is even.
- Not defined:
  - PARITY state and parity logic are absent; the frame is 10 bits.
- Port list is identical in both builds.

## Test plan
- Reset and idle, BPS=4: assert `rst`, then release and wait 20 cycles → `tx_pin` = 1, `tx_busy` = 0 and `tx_done_sig` = 0 throughout.
- Single byte, BPS=4, `tx_data`=8'h55, 1-cycle `tx_en_sig`:
  - `tx_pin` reads 0,1,0,1,0,1,0,1,0,1, each level for 4 cycles.
  - `tx_done_sig` pulses once, 40 cycles after the accept edge.
- Busy rejection, BPS=4:
  - Send 8'hA3; pulse `tx_en_sig` with 8'hFF at cycle 15.
  - Expect exactly one frame carrying 8'hA3, with no second frame.
- Back-to-back, BPS=4:
  - Hold `tx_en_sig`=1 with 8'h00, then 8'hFF presented in the done cycle.
  - Expect two contiguous 40-cycle frames and a single 4-cycle stop bit between them.
- Reset mid-frame, BPS=4:
  - Assert `rst` during data bit 3 of 8'h0F.
  - Expect `tx_pin`=1 and `tx_busy`=0 asynchronously, and no `tx_done_sig`.
  - A request after release transmits correctly.
- Parity (`UART_TX_PARITY_EN`), BPS=4:
  - 8'h07 → parity bit 1 and frame length 44 cycles.
  - 8'h03 → parity bit 0.
